// File: rtl/pool_rr_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pool_rr_scheduler_pkg
// Description : Shared constants for the sum-pool round-robin scheduler:
//               FSM state encoding and the Q8.8 sample width.
// Revision    : 1.0 - initial release
// ============================================================================
package pool_rr_scheduler_pkg;

  // Q8.8 fixed-point sample width used on both engine streams
  localparam int DATA_WIDTH_Q88 = 16;

  // Scheduler FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/pool_rr_scheduler_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : pool_rr_scheduler_rr_pick
// Description : Combinational circular priority pick. Returns the first set
//               request bit at or after i_ptr, wrapping at NUM_REQ, as a
//               one-hot vector plus its index.
// Revision    : 1.0 - initial release
// ============================================================================
module pool_rr_scheduler_rr_pick #(
  parameter  int NUM_REQ  = 4,
  localparam int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  i_req,
  input  logic [ID_WIDTH-1:0] i_ptr,
  output logic [NUM_REQ-1:0]  o_grant,
  output logic [ID_WIDTH-1:0] o_idx,
  output logic                o_valid
);

  // One extra bit so ptr + offset cannot overflow before the wrap
  logic [ID_WIDTH:0]   w_sum;
  logic [ID_WIDTH-1:0] w_pos;

  // Walk the requesters starting at i_ptr; the first hit wins
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_sum   = '0;
    w_pos   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_sum = {1'b0, i_ptr} + (ID_WIDTH+1)'(i);
      if (w_sum >= (ID_WIDTH+1)'(NUM_REQ)) begin
        w_sum = w_sum - (ID_WIDTH+1)'(NUM_REQ);
      end
      w_pos = w_sum[ID_WIDTH-1:0];
      if (!o_valid && i_req[w_pos]) begin
        o_valid        = 1'b1;
        o_grant[w_pos] = 1'b1;
        o_idx          = w_pos;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pool_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : pool_rr_scheduler
// Description : Round-robin owner arbitration for one shared sum-pool engine.
//               Issues the engine start pulse, muxes the owner's input stream
//               into the engine and routes the result stream back to it.
// Revision    : 1.0 - initial release
// ============================================================================
module pool_rr_scheduler
  import pool_rr_scheduler_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = DATA_WIDTH_Q88,
  localparam int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            i_req,
  output logic [NUM_REQ-1:0]            o_grant,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic [DATA_WIDTH-1:0]         o_res_data,
  output logic [NUM_REQ-1:0]            o_res_valid,
  input  logic [NUM_REQ-1:0]            i_res_ready,
  output logic [NUM_REQ-1:0]            o_job_done,
  output logic                          o_busy,
  output logic [ID_WIDTH-1:0]           o_cur_id,
  output logic                          o_pool_start,
  output logic [DATA_WIDTH-1:0]         o_pool_data,
  output logic                          o_pool_valid,
  input  logic                          i_pool_ready_in,
  input  logic [DATA_WIDTH-1:0]         i_pool_res,
  input  logic                          i_pool_res_valid,
  output logic                          o_pool_ready_out,
  input  logic                          i_pool_done
);

  state_t              r_state;
  logic [NUM_REQ-1:0]  r_grant;
  logic [ID_WIDTH-1:0] r_cur_id;
  logic [ID_WIDTH-1:0] r_rr_ptr;
  logic                r_busy;
  logic                r_pool_start;

  logic [NUM_REQ-1:0]    w_pick_grant;
  logic [ID_WIDTH-1:0]   w_pick_idx;
  logic                  w_pick_valid;
  logic [ID_WIDTH-1:0]   w_next_ptr;
  logic                  w_run;
  logic [DATA_WIDTH-1:0] w_req_data [NUM_REQ];

  pool_rr_scheduler_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .i_req   (i_req),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_pick_grant),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

  // Split the packed sample bus into one lane per requester
  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign w_req_data[k] = i_req_data[k*DATA_WIDTH +: DATA_WIDTH];
  end

  // The served requester drops to lowest priority for the next pick
  assign w_next_ptr = (r_cur_id == ID_WIDTH'(NUM_REQ-1)) ? '0 : r_cur_id + 1'b1;
  assign w_run      = (r_state == ST_RUN);

  // Arbitration FSM: pick in IDLE, pulse start, hold ownership until done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_grant      <= '0;
      r_cur_id     <= '0;
      r_rr_ptr     <= '0;
      r_busy       <= 1'b0;
      r_pool_start <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pick_valid) begin
            r_grant      <= w_pick_grant;
            r_cur_id     <= w_pick_idx;
            r_busy       <= 1'b1;
            r_pool_start <= 1'b1;
            r_state      <= ST_START;
          end
        end
        ST_START: begin
          r_pool_start <= 1'b0;
          r_state      <= ST_RUN;
        end
        ST_RUN: begin
          if (i_pool_done) begin
            r_grant  <= '0;
            r_busy   <= 1'b0;
            r_rr_ptr <= w_next_ptr;
            r_state  <= ST_IDLE;
          end
        end
        default: begin
          r_grant      <= '0;
          r_busy       <= 1'b0;
          r_pool_start <= 1'b0;
          r_state      <= ST_IDLE;
        end
      endcase
    end
  end

  // Per-requester handshake routing, only the owner sees traffic in RUN
  always_comb begin
    o_req_ready = '0;
    o_res_valid = '0;
    o_job_done  = '0;
    if (w_run) begin
      o_req_ready[r_cur_id] = i_pool_ready_in;
      o_res_valid[r_cur_id] = i_pool_res_valid;
      o_job_done[r_cur_id]  = i_pool_done;
    end
  end

  assign o_pool_data      = w_run ? w_req_data[r_cur_id] : '0;
  assign o_pool_valid     = w_run & i_req_valid[r_cur_id];
  assign o_pool_ready_out = w_run & i_res_ready[r_cur_id];
  assign o_res_data       = w_run ? i_pool_res : '0;

  assign o_grant      = r_grant;
  assign o_cur_id     = r_cur_id;
  assign o_busy       = r_busy;
  assign o_pool_start = r_pool_start;

  // Ownership is at most one requester, and present exactly outside IDLE
  a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(r_grant));
  a_grant_state: assert property (@(posedge clk) disable iff (!rst_n)
    ((r_grant != '0) == (r_state != ST_IDLE)));

endmodule
`default_nettype wire

// File: tb/tb_pool_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_pool_rr_scheduler
// Description : Directed self-checking bench for pool_rr_scheduler and its
//               rr_pick helper. The bench plays the pool engine by hand.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pool_rr_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [3:0]  grant;
  logic [63:0] req_data = '0;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_ready;
  logic [15:0] res_data;
  logic [3:0]  res_valid;
  logic [3:0]  res_ready = '0;
  logic [3:0]  job_done;
  logic        busy;
  logic [1:0]  cur_id;
  logic        pool_start;
  logic [15:0] pool_data;
  logic        pool_valid;
  logic        pool_ready_in = 1'b0;
  logic [15:0] pool_res = '0;
  logic        pool_res_valid = 1'b0;
  logic        pool_ready_out;
  logic        pool_done = 1'b0;

  logic [3:0]  pk_req = '0;
  logic [1:0]  pk_ptr = '0;
  logic [3:0]  pk_grant;
  logic [1:0]  pk_idx;
  logic        pk_valid;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pool_rr_scheduler #(.NUM_REQ(4), .DATA_WIDTH(16)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_req            (req),
    .o_grant          (grant),
    .i_req_data       (req_data),
    .i_req_valid      (req_valid),
    .o_req_ready      (req_ready),
    .o_res_data       (res_data),
    .o_res_valid      (res_valid),
    .i_res_ready      (res_ready),
    .o_job_done       (job_done),
    .o_busy           (busy),
    .o_cur_id         (cur_id),
    .o_pool_start     (pool_start),
    .o_pool_data      (pool_data),
    .o_pool_valid     (pool_valid),
    .i_pool_ready_in  (pool_ready_in),
    .i_pool_res       (pool_res),
    .i_pool_res_valid (pool_res_valid),
    .o_pool_ready_out (pool_ready_out),
    .i_pool_done      (pool_done)
  );

  pool_rr_scheduler_rr_pick #(.NUM_REQ(4)) u_pick (
    .i_req   (pk_req),
    .i_ptr   (pk_ptr),
    .o_grant (pk_grant),
    .o_idx   (pk_idx),
    .o_valid (pk_valid)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {10'd0, grant, req_ready, res_data, res_valid, job_done, busy, cur_id,
            pool_start, pool_data, pool_valid, pool_ready_out};
  endfunction

  task automatic pick_vec(input logic [1:0] ptr, input logic [3:0] r,
                          input logic [3:0] eg, input logic [1:0] ei, input logic ev);
    pk_ptr = ptr;
    pk_req = r;
    #1;
    check_eq("pick_grant", pk_grant, eg);
    check_eq("pick_idx", pk_idx, ei);
    check_eq("pick_valid", pk_valid, ev);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req = '0; req_valid = '0; req_data = '0; res_ready = '0;
    pool_ready_in = 1'b0; pool_res = '0; pool_res_valid = 1'b0; pool_done = 1'b0;
    #1;
    check_eq("reset_outs", all_outs(), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Caller has set req in IDLE; the grant appears at the next negedge (START)
  task automatic run_job(input int k, input int nsamp, input logic [15:0] samp,
                         input logic [15:0] exp_res, input int stall, input bit noise,
                         input logic [3:0] next_req);
    logic [15:0] acc;
    logic [3:0]  oh;
    oh  = 4'b0001 << k;
    acc = '0;
    @(negedge clk); #1;
    check_eq("start_grant", grant, oh);
    check_eq("start_pulse", pool_start, 64'd1);
    check_eq("start_curid", cur_id, k);
    check_eq("start_busy", busy, 64'd1);
    check_eq("start_quiet", {req_ready, res_valid, pool_valid, pool_ready_out}, 64'd0);
    for (int s = 0; s < nsamp; s++) begin
      @(negedge clk);
      pool_res_valid = 1'b0; res_ready = '0; pool_ready_in = 1'b1;
      req_valid = oh;
      req_data[k*16 +: 16] = samp;
      if (noise) begin
        req_valid[2] = 1'b1;
        req_data[2*16 +: 16] = 16'hBEEF;
      end
      #1;
      check_eq("in_data", pool_data, samp);
      check_eq("in_valid", pool_valid, 64'd1);
      check_eq("in_ready", req_ready, oh);
      check_eq("in_start_low", pool_start, 64'd0);
      acc = acc + samp;
      if (s % 4 == 3) begin
        for (int b = 0; b <= stall; b++) begin
          @(negedge clk);
          req_valid = '0; pool_ready_in = 1'b0;
          pool_res = acc; pool_res_valid = 1'b1;
          res_ready = (b == stall) ? oh : 4'b0000;
          #1;
          check_eq("res_valid", res_valid, oh);
          check_eq("res_data", res_data, exp_res);
          check_eq("res_rdy_out", pool_ready_out, (b == stall) ? 64'd1 : 64'd0);
          check_eq("res_in_rdy", req_ready, 64'd0);
        end
        stall = 0;
        acc = '0;
      end
    end
    @(negedge clk);
    pool_res_valid = 1'b0; res_ready = '0; req_valid = '0; pool_ready_in = 1'b0;
    pool_done = 1'b1;
    #1;
    check_eq("done_pulse", job_done, oh);
    check_eq("done_grant", grant, oh);
    check_eq("done_busy", busy, 64'd1);
    @(negedge clk);
    pool_done = 1'b0;
    #1;
    check_eq("idle_grant", grant, 64'd0);
    check_eq("idle_done", job_done, 64'd0);
    check_eq("idle_busy", busy, 64'd0);
    req = next_req;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // rr_pick standalone
    pick_vec(2'd0, 4'b0000, 4'b0000, 2'd0, 1'b0);
    pick_vec(2'd0, 4'b0100, 4'b0100, 2'd2, 1'b1);
    pick_vec(2'd3, 4'b1001, 4'b1000, 2'd3, 1'b1);
    pick_vec(2'd1, 4'b1001, 4'b1000, 2'd3, 1'b1);
    pick_vec(2'd2, 4'b0011, 4'b0001, 2'd0, 1'b1);
    pick_vec(2'd1, 4'b1111, 4'b0010, 2'd1, 1'b1);
    pick_vec(2'd3, 4'b0111, 4'b0001, 2'd0, 1'b1);

    do_reset();

    // Single requester, 64 samples of 1.0 -> 16 sums of 4.0
    @(negedge clk);
    req = 4'b0100;
    #1;
    check_eq("t1_no_grant_yet", grant, 64'd0);
    run_job(2, 64, 16'h0100, 16'h0400, 0, 1'b0, 4'b0000);

    // Pointer now at 3: requester 3 first, then wrap to 0 with noise on lane 2
    @(negedge clk);
    req = 4'b1001;
    #1;
    check_eq("t3_idle", grant, 64'd0);
    run_job(3, 4, 16'h0200, 16'h0800, 0, 1'b0, 4'b1001);
    run_job(0, 4, 16'h0123, 16'h048C, 0, 1'b1, 4'b0000);

    // Engine done while idle must not produce a completion
    @(negedge clk);
    pool_done = 1'b1;
    #1;
    check_eq("idle_done_ignored", job_done, 64'd0);
    @(negedge clk);
    pool_done = 1'b0;
    #1;
    check_eq("idle_stays", {grant, busy}, 64'd0);

    // All requesters held: 0,1,2,3 with one idle cycle between jobs
    do_reset();
    @(negedge clk);
    req = 4'b1111;
    run_job(0, 4, 16'h0100, 16'h0400, 0, 1'b0, 4'b1111);
    run_job(1, 4, 16'h0100, 16'h0400, 0, 1'b0, 4'b1111);
    run_job(2, 4, 16'h0100, 16'h0400, 0, 1'b0, 4'b1111);
    run_job(3, 4, 16'h0100, 16'h0400, 0, 1'b0, 4'b0000);

    // Result backpressure on requester 1 for 5 cycles
    @(negedge clk);
    req = 4'b0010;
    run_job(1, 8, 16'h0080, 16'h0200, 5, 1'b0, 4'b0000);

    // Reset in the middle of a job
    @(negedge clk);
    req = 4'b0001;
    @(negedge clk); #1;
    check_eq("t6_grant", grant, 64'd1);
    for (int s = 0; s < 10; s++) begin
      @(negedge clk);
      req_valid = 4'b0001; req_data[15:0] = 16'(s); pool_ready_in = 1'b1;
    end
    @(negedge clk);
    rst_n = 1'b0;
    req = 4'b0010; pool_done = 1'b1; pool_res_valid = 1'b1; req_valid = 4'b1111;
    #1;
    check_eq("t6_reset_outs", all_outs(), 64'd0);
    check_eq("t6_no_done", job_done, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pool_done = 1'b0; pool_res_valid = 1'b0; req_valid = '0; pool_ready_in = 1'b0;
    #1;
    check_eq("t6_idle_after", grant, 64'd0);
    @(negedge clk); #1;
    check_eq("t6_first_grant", grant, 64'b0010);
    check_eq("t6_start", pool_start, 64'd1);
    @(negedge clk);
    req = '0; pool_done = 1'b1;
    #1;
    check_eq("t6_done", job_done, 64'b0010);
    @(negedge clk);
    pool_done = 1'b0;
    #1;
    check_eq("t6_end_idle", grant, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pool_rr_scheduler.md
Name: pool_rr_scheduler

Overview:
- Shares one global sum-pool engine (Q8.8 in/out, channel-major stream) among NUM_REQ requesters, e.g. discriminator branches, using round-robin arbitration.
- Issues the engine start pulse and muxes the winner's input stream into the engine.
- Routes the per-channel result stream back to the winner and signals job completion.
- Sits between the feature-extraction layers and the dense head.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
DATA_WIDTH, 16, Q8.8 sample width
ID_WIDTH, $clog2(NUM_REQ), requester index width (localparam)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req  in  NUM_REQ  per-requester job request, level
grant  out  NUM_REQ  one-hot owner of the engine
req_data  in  NUM_REQ*DATA_WIDTH  packed input samples, requester k at bits [k*DATA_WIDTH +: DATA_WIDTH]
req_valid  in  NUM_REQ  input sample valid
req_ready  out  NUM_REQ  input sample accepted
res_data  out  DATA_WIDTH  pooled channel sum, broadcast to all requesters
res_valid  out  NUM_REQ  result valid, owner only
res_ready  in  NUM_REQ  result accept
job_done  out  NUM_REQ  one-cycle completion pulse
busy  out  1  high while a job is in flight
cur_id  out  ID_WIDTH  index of the current owner
pool_start  out  1  engine start pulse
pool_data  out  DATA_WIDTH  muxed input sample
pool_valid  out  1  muxed input valid
pool_ready_in  in  1  engine input ready
pool_res  in  DATA_WIDTH  engine output sample
pool_res_valid  in  1  engine output valid
pool_ready_out  out  1  engine output ready
pool_done  in  1  engine done, one cycle

Behaviour:
- Reset: all outputs 0; state=IDLE; rr_ptr=0; cur_id=0. A reset in mid-job abandons the job with no job_done pulse. The engine shares rst_n.
- States: IDLE, START, RUN.
- IDLE: if req != 0, pick the first set bit at or after rr_ptr, searching circularly. Register grant (one-hot) and cur_id, then go to START. If req==0, stay.
- START, one cycle: pool_start=1, busy=1, then go to RUN.
- RUN: busy=1.
  - pool_data = req_data[cur_id]; pool_valid = req_valid[cur_id].
  - req_ready[cur_id] = pool_ready_in. All other req_ready bits are 0.
  - res_data = pool_res; res_valid[cur_id] = pool_res_valid; pool_ready_out = res_ready[cur_id].
  - On pool_done: job_done[cur_id]=1 for that cycle, rr_ptr <= cur_id+1 modulo NUM_REQ, grant cleared next edge, go to IDLE.
- Arbitration latency: req sampled in IDLE gives grant at the next edge. pool_start is high the cycle after that. Minimum gap between back-to-back jobs is one IDLE cycle, which matches the engine's return to idle.
- grant is stable from START through the pool_done cycle inclusive. req changes during a job are ignored. A request dropped mid-job does not abort the job.
- The owner must keep req high until job_done if it wants consecutive jobs. Fairness rule: a requester that is still asserting req after its job is served is served last among the pending requesters.
- Outside RUN: pool_valid=0, pool_ready_out=0, and all req_ready and res_valid bits are 0.
- The data muxes are combinational from registered cur_id. No arithmetic is performed and data is passed bit-exact.
- pool_done outside RUN is ignored.
- Invariants for assertions: $onehot0(grant); grant!=0 iff state!=IDLE.

Decomposition:
- Shared package holds the state encoding constants (ST_IDLE=2'd0, ST_START=2'd1, ST_RUN=2'd2) and the Q8.8 DATA_WIDTH constant.
- One natural sub-module, rr_pick, is purely combinational. Inputs: req, rr_ptr. Outputs: the one-hot winner and its index. Verify it standalone.

Test Plan:
1. Single requester: req=4'b0100, stream 64 samples of 16'h0100 -> grant=4'b0100 one edge later; pool_start high for one cycle; each res_valid[2] beat is 16'h0400; job_done[2] pulses once; then grant=0.
2. All requesters: req=4'b1111 held for 4 jobs -> grant order 0,1,2,3, with exactly one IDLE cycle between jobs.
3. Pointer wrap: rr_ptr=3, req=4'b1001 -> grant 3 first, then 0.
4. Backpressure: res_ready[1]=0 for 5 cycles in RUN -> pool_ready_out=0 and the result data is held. res_valid[0], res_valid[2] and res_valid[3] stay 0 throughout.
5. Isolation: requester 2 drives req_valid=1 while requester 0 owns the engine -> req_ready[2]=0, and pool_data equals req_data[0].
6. Reset mid-RUN: assert rst_n=0 at sample 10 -> all outputs 0 and no job_done. After release with req=4'b0010, the first grant is 4'b0010.
